// File: rtl/rtc_calendar_core_if.sv
// Field-write and alarm-programming bus of the RTC calendar core.
interface rtc_calendar_core_if #(
  parameter int N_ALARM = 2
);
  localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

  logic               wr_valid;
  logic [1:0]         wr_op;
  logic [2:0]         wr_field;
  logic [13:0]        wr_value;
  logic               wr_err;
  logic               al_wr;
  logic [AW-1:0]      al_idx;
  logic [4:0]         al_hour;
  logic [5:0]         al_min;
  logic               al_en;
  logic [N_ALARM-1:0] al_ack;
  logic [N_ALARM-1:0] alarm_hit;

  modport slave (
    input  wr_valid, wr_op, wr_field, wr_value, al_wr, al_idx, al_hour, al_min, al_en, al_ack,
    output wr_err, alarm_hit
  );
  modport master (
    output wr_valid, wr_op, wr_field, wr_value, al_wr, al_idx, al_hour, al_min, al_en, al_ack,
    input  wr_err, alarm_hit
  );
endinterface

// File: rtl/rtc_calendar_core.sv
// Time-of-day / Gregorian calendar engine with field load/adjust and N daily hour:min alarms.
module rtc_calendar_core #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int N_ALARM    = 2,
  parameter int YEAR_RESET = 2024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_run,
  rtc_calendar_core_if.slave  bus,
  output logic [5:0]          o_sec,
  output logic [5:0]          o_min,
  output logic [4:0]          o_hour,
  output logic [4:0]          o_day,
  output logic [3:0]          o_month,
  output logic [13:0]         o_year,
  output logic                o_tick_1s,
  output logic                o_half_s
);
  localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] P_HALF = PW'(CLK_HZ / 2 - 1);

  function automatic logic f_leap(input logic [13:0] y);
    return (y[1:0] == 2'b00) && (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
  endfunction

  function automatic logic [4:0] f_dim(input logic [3:0] m, input logic [13:0] y);
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return f_leap(y) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic          r_tick, r_half, r_adv, r_err;
  logic [5:0]    r_sec, r_min;
  logic [4:0]    r_hour, r_day;
  logic [3:0]    r_month;
  logic [13:0]   r_year;
  logic [4:0]    r_al_hour [N_ALARM];
  logic [5:0]    r_al_min  [N_ALARM];
  logic [N_ALARM-1:0] r_al_en, r_hit;

  logic [13:0]   w_cur, w_lo, w_hi, w_res;
  logic          w_fld_ok, w_acc, w_wr, w_tick, w_adv;
  logic [4:0]    w_dim_cur, w_dim_new;
  logic [N_ALARM-1:0] w_al_set;

  assign w_tick = i_run && (r_presc == P_TERM);

  // Field write decode: range/wrap limits of the addressed field, result and acceptance
  always_comb begin
    w_cur     = '0;
    w_lo      = '0;
    w_hi      = '0;
    w_fld_ok  = 1'b1;
    w_dim_cur = f_dim(r_month, r_year);
    case (bus.wr_field)
      3'd0: begin w_cur = 14'(r_sec);   w_hi = 14'd59; end
      3'd1: begin w_cur = 14'(r_min);   w_hi = 14'd59; end
      3'd2: begin w_cur = 14'(r_hour);  w_hi = 14'd23; end
      3'd3: begin w_cur = 14'(r_day);   w_lo = 14'd1; w_hi = 14'(w_dim_cur); end
      3'd4: begin w_cur = 14'(r_month); w_lo = 14'd1; w_hi = 14'd12; end
      3'd5: begin w_cur = r_year;       w_hi = 14'd9999; end
      default: w_fld_ok = 1'b0;
    endcase
    w_res = bus.wr_value;
    w_acc = 1'b0;
    case (bus.wr_op)
      2'd0: w_acc = w_fld_ok && (bus.wr_value >= w_lo) && (bus.wr_value <= w_hi);
      2'd1: begin w_res = (w_cur >= w_hi) ? w_lo : w_cur + 14'd1; w_acc = w_fld_ok; end
      2'd2: begin w_res = (w_cur <= w_lo) ? w_hi : w_cur - 14'd1; w_acc = w_fld_ok; end
      default: w_acc = 1'b0;
    endcase
    w_wr      = bus.wr_valid && w_acc;
    w_dim_new = (bus.wr_field == 3'd4) ? f_dim(w_res[3:0], r_year) : f_dim(r_month, w_res);
    w_adv     = w_tick && !w_wr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_half  <= 1'b0;
    end else begin
      r_tick <= w_tick;
      if (w_wr && (bus.wr_field == 3'd0)) r_presc <= '0;
      else if (i_run) r_presc <= (r_presc == P_TERM) ? '0 : r_presc + PW'(1);
      if (i_run && ((r_presc == P_HALF) || (r_presc == P_TERM))) r_half <= ~r_half;
    end
  end

  // An accepted write takes precedence over the second advance of the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sec   <= '0;
      r_min   <= '0;
      r_hour  <= '0;
      r_day   <= 5'd1;
      r_month <= 4'd1;
      r_year  <= 14'(YEAR_RESET);
      r_adv   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_adv <= w_adv;
      r_err <= bus.wr_valid && !w_acc;
      if (w_wr) begin
        case (bus.wr_field)
          3'd0: r_sec  <= w_res[5:0];
          3'd1: r_min  <= w_res[5:0];
          3'd2: r_hour <= w_res[4:0];
          3'd3: r_day  <= w_res[4:0];
          3'd4: begin
            r_month <= w_res[3:0];
            if (r_day > w_dim_new) r_day <= w_dim_new;
          end
          3'd5: begin
            r_year <= w_res;
            if (r_day > w_dim_new) r_day <= w_dim_new;
          end
          default: ;
        endcase
      end else if (w_tick) begin
        r_sec <= (r_sec == 6'd59) ? 6'd0 : r_sec + 6'd1;
        if (r_sec == 6'd59) begin
          r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
          if (r_min == 6'd59) begin
            r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
            if (r_hour == 5'd23) begin
              r_day <= (r_day == w_dim_cur) ? 5'd1 : r_day + 5'd1;
              if (r_day == w_dim_cur) begin
                r_month <= (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                if (r_month == 4'd12) r_year <= (r_year == 14'd9999) ? 14'd0 : r_year + 14'd1;
              end
            end
          end
        end
      end
    end
  end

  // Alarm match is evaluated on the time produced by the previous cycle's advance
  always_comb begin
    w_al_set = '0;
    for (int i = 0; i < N_ALARM; i++)
      w_al_set[i] = r_adv && (r_sec == 6'd0) && r_al_en[i] &&
                    (r_hour == r_al_hour[i]) && (r_min == r_al_min[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ALARM; i++) begin
        r_al_hour[i] <= '0;
        r_al_min[i]  <= '0;
      end
      r_al_en <= '0;
      r_hit   <= '0;
    end else begin
      for (int i = 0; i < N_ALARM; i++) begin
        if (bus.al_wr && (bus.al_idx == AW'(i))) begin
          r_al_hour[i] <= bus.al_hour;
          r_al_min[i]  <= bus.al_min;
          r_al_en[i]   <= bus.al_en;
        end
      end
      r_hit <= (r_hit & ~bus.al_ack) | w_al_set;
    end
  end

  assign bus.wr_err    = r_err;
  assign bus.alarm_hit = r_hit;
  assign o_sec         = r_sec;
  assign o_min         = r_min;
  assign o_hour        = r_hour;
  assign o_day         = r_day;
  assign o_month       = r_month;
  assign o_year        = r_year;
  assign o_tick_1s     = r_tick;
  assign o_half_s      = r_half;
endmodule

// File: tb/tb_rtc_calendar_core.sv
// Directed bench for rtc_calendar_core: write-vector table plus rollover, leap, alarm and priority sequences.
module tb_rtc_calendar_core;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        run;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour, o_day;
  logic [3:0]  o_month;
  logic [13:0] o_year;
  logic        o_tick_1s, o_half_s;
  int          n_vec = 0;
  int          n_bad = 0;

  rtc_calendar_core_if #(.N_ALARM(2)) bus ();

  rtc_calendar_core #(.CLK_HZ(10), .N_ALARM(2), .YEAR_RESET(2024)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(run), .bus(bus),
    .o_sec(o_sec), .o_min(o_min), .o_hour(o_hour), .o_day(o_day), .o_month(o_month),
    .o_year(o_year), .o_tick_1s(o_tick_1s), .o_half_s(o_half_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op; int fld; int val; int err;
    int h; int mi; int s; int d; int mo; int y;
  } vec_t;
  vec_t tbl [33];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_time(input string nm, input int h, input int mi, input int s,
                            input int d, input int mo, input int y);
    n_vec++;
    if (o_hour !== 5'(h) || o_min !== 6'(mi) || o_sec !== 6'(s) ||
        o_day !== 5'(d) || o_month !== 4'(mo) || o_year !== 14'(y)) begin
      n_bad++;
      $display("FAIL %s: got %0d:%0d:%0d %0d-%0d-%0d expected %0d:%0d:%0d %0d-%0d-%0d", nm,
               o_hour, o_min, o_sec, o_day, o_month, o_year, h, mi, s, d, mo, y);
    end
  endtask

  task automatic wr(input int op, input int fld, input int val);
    bus.wr_valid = 1'b1;
    bus.wr_op    = 2'(op);
    bus.wr_field = 3'(fld);
    bus.wr_value = 14'(val);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic set_time(input int h, input int mi, input int s, input int d, input int mo, input int y);
    wr(0, 5, y);
    wr(0, 4, mo);
    wr(0, 3, d);
    wr(0, 2, h);
    wr(0, 1, mi);
    wr(0, 0, s);
  endtask

  task automatic wait_tick(output int k);
    k = -1;
    run = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (o_tick_1s) begin
        k = i;
        break;
      end
    end
    run = 1'b0;
  endtask

  initial begin
    int k;
    //        op fld  val   err  h  mi  s   d  mo  y
    tbl[0]  = '{0, 0, 60,    1,  0, 0,  0,  1, 1, 2024};
    tbl[1]  = '{0, 0, 45,    0,  0, 0,  45, 1, 1, 2024};
    tbl[2]  = '{0, 6, 0,     1,  0, 0,  45, 1, 1, 2024};
    tbl[3]  = '{3, 0, 0,     1,  0, 0,  45, 1, 1, 2024};
    tbl[4]  = '{2, 2, 0,     0,  23, 0, 45, 1, 1, 2024};
    tbl[5]  = '{1, 1, 0,     0,  23, 1, 45, 1, 1, 2024};
    tbl[6]  = '{2, 1, 0,     0,  23, 0, 45, 1, 1, 2024};
    tbl[7]  = '{2, 1, 0,     0,  23, 59, 45, 1, 1, 2024};
    tbl[8]  = '{0, 3, 31,    0,  23, 59, 45, 31, 1, 2024};
    tbl[9]  = '{0, 5, 2023,  0,  23, 59, 45, 31, 1, 2023};
    tbl[10] = '{0, 4, 2,     0,  23, 59, 45, 28, 2, 2023};
    tbl[11] = '{1, 5, 0,     0,  23, 59, 45, 28, 2, 2024};
    tbl[12] = '{0, 3, 29,    0,  23, 59, 45, 29, 2, 2024};
    tbl[13] = '{0, 3, 30,    1,  23, 59, 45, 29, 2, 2024};
    tbl[14] = '{1, 5, 0,     0,  23, 59, 45, 28, 2, 2025};
    tbl[15] = '{1, 3, 0,     0,  23, 59, 45, 1, 2, 2025};
    tbl[16] = '{2, 3, 0,     0,  23, 59, 45, 28, 2, 2025};
    tbl[17] = '{0, 4, 13,    1,  23, 59, 45, 28, 2, 2025};
    tbl[18] = '{0, 4, 0,     1,  23, 59, 45, 28, 2, 2025};
    tbl[19] = '{0, 5, 10000, 1,  23, 59, 45, 28, 2, 2025};
    tbl[20] = '{0, 5, 9999,  0,  23, 59, 45, 28, 2, 9999};
    tbl[21] = '{1, 5, 0,     0,  23, 59, 45, 28, 2, 0};
    tbl[22] = '{2, 5, 0,     0,  23, 59, 45, 28, 2, 9999};
    tbl[23] = '{1, 0, 0,     0,  23, 59, 46, 28, 2, 9999};
    tbl[24] = '{0, 0, 59,    0,  23, 59, 59, 28, 2, 9999};
    tbl[25] = '{1, 0, 0,     0,  23, 59, 0,  28, 2, 9999};
    tbl[26] = '{2, 4, 0,     0,  23, 59, 0,  28, 1, 9999};
    tbl[27] = '{2, 4, 0,     0,  23, 59, 0,  28, 12, 9999};
    tbl[28] = '{0, 2, 24,    1,  23, 59, 0,  28, 12, 9999};
    tbl[29] = '{1, 2, 0,     0,  0, 59,  0,  28, 12, 9999};
    tbl[30] = '{0, 3, 0,     1,  0, 59,  0,  28, 12, 9999};
    tbl[31] = '{0, 3, 31,    0,  0, 59,  0,  31, 12, 9999};
    tbl[32] = '{1, 7, 0,     1,  0, 59,  0,  31, 12, 9999};

    reset_n = 1'b0;
    run = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_op = '0; bus.wr_field = '0; bus.wr_value = '0;
    bus.al_wr = 1'b0; bus.al_idx = '0; bus.al_hour = '0; bus.al_min = '0;
    bus.al_en = 1'b0; bus.al_ack = '0;
    repeat (3) step();
    check_time("reset_time", 0, 0, 0, 1, 1, 2024);
    chk("reset_tick", 32'(o_tick_1s), 0);
    chk("reset_half", 32'(o_half_s), 0);
    chk("reset_err", 32'(bus.wr_err), 0);
    chk("reset_hit", 32'(bus.alarm_hit), 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 33; i++) begin
      wr(tbl[i].op, tbl[i].fld, tbl[i].val);
      chk($sformatf("vec%0d_err", i), 32'(bus.wr_err), 32'(tbl[i].err));
      check_time($sformatf("vec%0d_time", i), tbl[i].h, tbl[i].mi, tbl[i].s,
                 tbl[i].d, tbl[i].mo, tbl[i].y);
    end
    step();
    chk("err_pulse_clears", 32'(bus.wr_err), 0);

    // Full rollover 23:59:59 31-Dec-9999 -> 00:00:00 01-Jan-0000
    wr(0, 2, 23);
    wr(0, 0, 59);
    check_time("pre_rollover", 23, 59, 59, 31, 12, 9999);
    run = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      if (c == 4)  chk("half_c4", 32'(o_half_s), 0);
      if (c == 5)  chk("half_c5", 32'(o_half_s), 1);
      if (c == 9)  chk("tick_c9", 32'(o_tick_1s), 0);
      if (c == 10) begin
        chk("tick_c10", 32'(o_tick_1s), 1);
        chk("half_c10", 32'(o_half_s), 0);
        check_time("rollover", 0, 0, 0, 1, 1, 0);
      end
      if (c == 11) chk("tick_c11", 32'(o_tick_1s), 0);
    end
    run = 1'b0;

    set_time(23, 59, 59, 28, 2, 2100);
    wait_tick(k);
    chk("tick_latency_2100", 32'(k), 10);
    check_time("feb_2100", 0, 0, 0, 1, 3, 2100);
    set_time(23, 59, 59, 28, 2, 2000);
    wait_tick(k);
    check_time("feb_2000", 0, 0, 0, 29, 2, 2000);
    set_time(23, 59, 59, 28, 2, 2024);
    wait_tick(k);
    check_time("feb_2024", 0, 0, 0, 29, 2, 2024);
    set_time(23, 59, 59, 29, 2, 2024);
    wait_tick(k);
    check_time("feb29_2024", 0, 0, 0, 1, 3, 2024);

    // Alarm 0 at 07:30 enabled, alarm 1 at 07:30 disabled
    bus.al_wr = 1'b1; bus.al_idx = 1'b0; bus.al_hour = 5'd7; bus.al_min = 6'd30; bus.al_en = 1'b1;
    step();
    bus.al_idx = 1'b1; bus.al_en = 1'b0;
    step();
    bus.al_wr = 1'b0;
    set_time(7, 29, 59, 1, 3, 2024);
    wait_tick(k);
    check_time("alarm_time", 7, 30, 0, 1, 3, 2024);
    chk("hit_not_yet", 32'(bus.alarm_hit), 0);
    step();
    chk("hit_set", 32'(bus.alarm_hit), 32'b01);

    set_time(7, 29, 59, 1, 3, 2024);
    chk("hit_sticky", 32'(bus.alarm_hit), 32'b01);
    wait_tick(k);
    bus.al_ack = 2'b01;
    step();
    bus.al_ack = 2'b00;
    chk("ack_vs_set", 32'(bus.alarm_hit), 32'b01);
    bus.al_ack = 2'b01;
    step();
    bus.al_ack = 2'b00;
    chk("ack_clears", 32'(bus.alarm_hit), 0);

    set_time(7, 29, 10, 1, 3, 2024);
    wr(0, 1, 30);
    step();
    step();
    check_time("write_to_alarm", 7, 30, 10, 1, 3, 2024);
    chk("write_no_hit", 32'(bus.alarm_hit), 0);

    // Sec load mid-second restarts the prescaler
    set_time(12, 0, 0, 1, 3, 2024);
    run = 1'b1;
    repeat (7) step();
    wr(0, 0, 5);
    check_time("sec_load_run", 12, 0, 5, 1, 3, 2024);
    wait_tick(k);
    chk("tick_after_sec_load", 32'(k), 10);
    check_time("after_sec_load", 12, 0, 6, 1, 3, 2024);

    // Write on the tick edge drops that advance
    set_time(12, 0, 20, 1, 3, 2024);
    run = 1'b1;
    repeat (9) step();
    wr(0, 1, 10);
    run = 1'b0;
    chk("tick_with_write", 32'(o_tick_1s), 1);
    check_time("write_wins", 12, 10, 20, 1, 3, 2024);

    // Asynchronous reset mid-operation with a pending hit
    set_time(7, 29, 59, 1, 3, 2024);
    wait_tick(k);
    step();
    chk("hit_before_reset", 32'(bus.alarm_hit), 32'b01);
    #2 reset_n = 1'b0;
    #1;
    check_time("async_reset_time", 0, 0, 0, 1, 1, 2024);
    chk("async_reset_hit", 32'(bus.alarm_hit), 0);
    step();
    step();
    reset_n = 1'b1;
    set_time(7, 29, 59, 1, 3, 2024);
    wait_tick(k);
    step();
    chk("alarm_disabled_after_reset", 32'(bus.alarm_hit), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
